// File: rtl/histogram_if.sv
// Readout link between computeHistogram (slave) and its consumer (master).
// The master requests a streamed readout and a clear; the slave streams
// per-axis bin counts with independent valids and acknowledges the clear.
interface histogram_if #(
    parameter int COUNT_W = 8
) ();
    logic               readHistogram;
    logic               clearHistogram;
    logic [COUNT_W-1:0] xHistogramOut;
    logic [COUNT_W-1:0] yHistogramOut;
    logic               xValid;
    logic               yValid;
    logic               histogramClear;

    modport master (
        output readHistogram,
        output clearHistogram,
        input  xHistogramOut,
        input  yHistogramOut,
        input  xValid,
        input  yValid,
        input  histogramClear
    );

    modport slave (
        input  readHistogram,
        input  clearHistogram,
        output xHistogramOut,
        output yHistogramOut,
        output xValid,
        output yValid,
        output histogramClear
    );
endinterface

// File: rtl/histogram_reader.sv
// Consumer of the computeHistogram readout: streams both axes, reduces them
// on the fly to peak / thresholded extent / sum, clears the histogram and
// reports the results with a one-cycle done pulse.
module histogram_reader #(
    parameter int X_BINS  = 240,
    parameter int Y_BINS  = 180,
    parameter int COUNT_W = 8,
    parameter int IDX_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] threshold,
    histogram_if.master        hist,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [IDX_W-1:0]   xPeakIdx,
    output logic [IDX_W-1:0]   yPeakIdx,
    output logic [COUNT_W-1:0] xPeakVal,
    output logic [COUNT_W-1:0] yPeakVal,
    output logic [IDX_W-1:0]   xMin,
    output logic [IDX_W-1:0]   xMax,
    output logic [IDX_W-1:0]   yMin,
    output logic [IDX_W-1:0]   yMax,
    output logic               objFound,
    output logic [15:0]        xSum,
    output logic [15:0]        ySum
);
    localparam int XC_W = $clog2(X_BINS + 1);
    localparam int YC_W = $clog2(Y_BINS + 1);
    localparam int TM_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [COUNT_W-1:0] thr;
    logic [XC_W-1:0]    x_cnt;
    logic [YC_W-1:0]    y_cnt;
    logic [TM_W-1:0]    idle_cnt;
    logic               x_found;
    logic               y_found;
    logic               read_req;
    logic               clear_req;

    logic x_full;
    logic y_full;
    logic x_take;
    logic y_take;
    logic any_beat;

    // Beats past the last bin of an axis are dropped; the idle timer still
    // treats any valid as activity.
    assign x_full   = (x_cnt == XC_W'(X_BINS));
    assign y_full   = (y_cnt == YC_W'(Y_BINS));
    assign x_take   = hist.xValid & ~x_full;
    assign y_take   = hist.yValid & ~y_full;
    assign any_beat = hist.xValid | hist.yValid;

    assign hist.readHistogram  = read_req;
    assign hist.clearHistogram = clear_req;
    assign objFound            = x_found & y_found;

    // Readout sequencer with on-the-fly reduction of both axes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            thr       <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            idle_cnt  <= '0;
            x_found   <= 1'b0;
            y_found   <= 1'b0;
            read_req  <= 1'b0;
            clear_req <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            xPeakIdx  <= '0;
            yPeakIdx  <= '0;
            xPeakVal  <= '0;
            yPeakVal  <= '0;
            xMin      <= '0;
            xMax      <= '0;
            yMin      <= '0;
            yMax      <= '0;
            xSum      <= 16'd0;
            ySum      <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        thr      <= threshold;
                        x_cnt    <= '0;
                        y_cnt    <= '0;
                        idle_cnt <= '0;
                        x_found  <= 1'b0;
                        y_found  <= 1'b0;
                        error    <= 1'b0;
                        xPeakIdx <= '0;
                        yPeakIdx <= '0;
                        xPeakVal <= '0;
                        yPeakVal <= '0;
                        xMin     <= '0;
                        xMax     <= '0;
                        yMin     <= '0;
                        yMax     <= '0;
                        xSum     <= 16'd0;
                        ySum     <= 16'd0;
                        read_req <= 1'b1;
                        busy     <= 1'b1;
                        state    <= READ;
                    end else begin
                        state <= IDLE;
                    end
                end
                READ: begin
                    if (x_full && y_full) begin
                        read_req  <= 1'b0;
                        clear_req <= 1'b1;
                        state     <= CLEAR;
                    end else begin
                        // Abort with partial results after TIMEOUT silent cycles.
                        if (any_beat) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == TM_W'(TIMEOUT - 1)) begin
                            error     <= 1'b1;
                            read_req  <= 1'b0;
                            clear_req <= 1'b1;
                            state     <= CLEAR;
                        end else begin
                            idle_cnt <= idle_cnt + TM_W'(1);
                        end
                        if (x_take) begin
                            x_cnt <= x_cnt + XC_W'(1);
                            xSum  <= xSum + 16'(hist.xHistogramOut);
                            // Strict compare keeps the lowest index on ties.
                            if (hist.xHistogramOut > xPeakVal) begin
                                xPeakVal <= hist.xHistogramOut;
                                xPeakIdx <= IDX_W'(x_cnt);
                            end
                            if (hist.xHistogramOut > thr) begin
                                if (!x_found) begin
                                    xMin <= IDX_W'(x_cnt);
                                end
                                xMax    <= IDX_W'(x_cnt);
                                x_found <= 1'b1;
                            end
                        end
                        if (y_take) begin
                            y_cnt <= y_cnt + YC_W'(1);
                            ySum  <= ySum + 16'(hist.yHistogramOut);
                            if (hist.yHistogramOut > yPeakVal) begin
                                yPeakVal <= hist.yHistogramOut;
                                yPeakIdx <= IDX_W'(y_cnt);
                            end
                            if (hist.yHistogramOut > thr) begin
                                if (!y_found) begin
                                    yMin <= IDX_W'(y_cnt);
                                end
                                yMax    <= IDX_W'(y_cnt);
                                y_found <= 1'b1;
                            end
                        end
                    end
                end
                CLEAR: begin
                    if (hist.histogramClear) begin
                        clear_req <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= CLEAR;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    read_req  <= 1'b0;
                    clear_req <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_histogram_reader.sv
// Scoreboard bench for histogram_reader: expected reductions are computed
// from the bench's own bin arrays when a readout is driven and compared
// when done is observed.
module tb_histogram_reader;
    localparam int X_BINS = 240;
    localparam int Y_BINS = 180;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] threshold;
    logic       busy, done, error, objFound;
    logic [7:0] xPeakIdx, yPeakIdx, xPeakVal, yPeakVal;
    logic [7:0] xMin, xMax, yMin, yMax;
    logic [15:0] xSum, ySum;

    histogram_if #(.COUNT_W(8)) hif ();

    histogram_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .threshold (threshold),
        .hist      (hif),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .xPeakIdx  (xPeakIdx),
        .yPeakIdx  (yPeakIdx),
        .xPeakVal  (xPeakVal),
        .yPeakVal  (yPeakVal),
        .xMin      (xMin),
        .xMax      (xMax),
        .yMin      (yMin),
        .yMax      (yMax),
        .objFound  (objFound),
        .xSum      (xSum),
        .ySum      (ySum)
    );

    typedef struct {
        logic [7:0]  xpi, xpv, ypi, ypv;
        logic [7:0]  xmin, xmax, ymin, ymax;
        logic        obj, err;
        logic [15:0] xs, ys;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] xb[X_BINS];
    logic [7:0] yb[Y_BINS];
    int         n_checks = 0;
    int         n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference reduction over the first nx / ny bins of the bench arrays.
    function automatic exp_t model(input logic [7:0] thr, input int nx, input int ny, input logic err);
        exp_t r;
        logic xf, yf;
        r = '{xpi: 8'd0, xpv: 8'd0, ypi: 8'd0, ypv: 8'd0, xmin: 8'd0, xmax: 8'd0,
              ymin: 8'd0, ymax: 8'd0, obj: 1'b0, err: err, xs: 16'd0, ys: 16'd0};
        xf = 1'b0;
        yf = 1'b0;
        for (int i = 0; i < nx; i++) begin
            r.xs += 16'(xb[i]);
            if (xb[i] > r.xpv) begin r.xpv = xb[i]; r.xpi = 8'(i); end
            if (xb[i] > thr) begin
                if (!xf) r.xmin = 8'(i);
                r.xmax = 8'(i);
                xf = 1'b1;
            end
        end
        for (int i = 0; i < ny; i++) begin
            r.ys += 16'(yb[i]);
            if (yb[i] > r.ypv) begin r.ypv = yb[i]; r.ypi = 8'(i); end
            if (yb[i] > thr) begin
                if (!yf) r.ymin = 8'(i);
                r.ymax = 8'(i);
                yf = 1'b1;
            end
        end
        r.obj = xf & yf;
        return r;
    endfunction

    task automatic compare_results();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("xPeakIdx", xPeakIdx, e.xpi);
            check("xPeakVal", xPeakVal, e.xpv);
            check("yPeakIdx", yPeakIdx, e.ypi);
            check("yPeakVal", yPeakVal, e.ypv);
            check("xMin", xMin, e.xmin);
            check("xMax", xMax, e.xmax);
            check("yMin", yMin, e.ymin);
            check("yMax", yMax, e.ymax);
            check("objFound", objFound, e.obj);
            check("error", error, e.err);
            check("xSum", xSum, e.xs);
            check("ySum", ySum, e.ys);
        end
    endtask

    // One complete readout. nx/ny < full means the source goes silent (timeout).
    task automatic run(input logic [7:0] thr, input int nx, input int ny, input bit interleave,
                       input int extra, input bit hc_pre, input bit rst_clear);
        int  xi, yi, ex, it, w;
        bit  rx, ry, tmo;
        tmo = (nx < X_BINS) || (ny < Y_BINS);
        @(negedge clk);
        start = 1'b1;
        threshold = thr;
        @(negedge clk);
        start = 1'b0;
        threshold = ~thr;
        check("start_read", hif.readHistogram, 1'b1);
        check("start_busy", busy, 1'b1);
        if (!rst_clear) sb.push_back(model(thr, nx, ny, tmo));
        xi = 0; yi = 0; ex = 0; it = 0;
        while (xi < nx || yi < ny || ex < extra) begin
            hif.xValid = 1'b0;
            hif.yValid = 1'b0;
            rx = interleave ? ($urandom_range(0, 2) != 0) : 1'b1;
            ry = interleave ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (xi < nx) begin
                if (rx) begin hif.xHistogramOut = xb[xi]; hif.xValid = 1'b1; xi++; end
            end else if (ex < extra && rx) begin
                hif.xHistogramOut = 8'd255; hif.xValid = 1'b1; ex++;
            end
            if (yi < ny && (yi < ny - 1 || ex >= extra) && ry) begin
                hif.yHistogramOut = yb[yi]; hif.yValid = 1'b1; yi++;
            end
            start = (it == 20);
            it++;
            @(negedge clk);
        end
        hif.xValid = 1'b0;
        hif.yValid = 1'b0;
        start = 1'b0;
        if (tmo) begin
            repeat (1023) @(negedge clk);
            check("tmo_early_clear", hif.clearHistogram, 1'b0);
            check("tmo_early_read", hif.readHistogram, 1'b1);
            @(negedge clk);
            check("tmo_clear", hif.clearHistogram, 1'b1);
            check("tmo_read", hif.readHistogram, 1'b0);
            check("tmo_error", error, 1'b1);
        end else begin
            check("read_hold", hif.readHistogram, 1'b1);
            check("clear_low", hif.clearHistogram, 1'b0);
            if (hc_pre) hif.histogramClear = 1'b1;
            @(negedge clk);
            check("read_drop", hif.readHistogram, 1'b0);
            check("clear_up", hif.clearHistogram, 1'b1);
        end
        if (rst_clear) begin
            #2 reset = 1'b1;
            #1;
            check("rst_clear", hif.clearHistogram, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_read", hif.readHistogram, 1'b0);
            @(negedge clk);
            reset = 1'b0;
            w = 0;
            repeat (8) begin
                @(negedge clk);
                if (done) w++;
            end
            check("rst_no_done", w, 0);
        end else begin
            if (!hc_pre) begin
                repeat (3) @(negedge clk);
                check("clear_hold", hif.clearHistogram, 1'b1);
                check("no_early_done", done, 1'b0);
                hif.histogramClear = 1'b1;
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
            w = 0;
            while (!done && w < 20) begin
                @(negedge clk);
                w++;
            end
            check("done_latency", w, 0);
            check("done_clear_low", hif.clearHistogram, 1'b0);
            if (done) compare_results();
            else check("done_seen", 1'b0, 1'b1);
            hif.histogramClear = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("done_one_cycle", done, 1'b0);
            check("idle_after", busy, 1'b0);
            @(negedge clk);
            check("done_start_ignored", busy, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        threshold = 8'd0;
        hif.xValid = 1'b0;
        hif.yValid = 1'b0;
        hif.xHistogramOut = 8'd0;
        hif.yHistogramOut = 8'd0;
        hif.histogramClear = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_readHistogram", hif.readHistogram, 1'b0);
        check("rst_clearHistogram", hif.clearHistogram, 1'b0);
        check("rst_busy0", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_xSum", xSum, 16'd0);

        // Flat stream, coincident beats.
        for (int i = 0; i < X_BINS; i++) xb[i] = 8'd3;
        for (int i = 0; i < Y_BINS; i++) yb[i] = 8'd3;
        run(8'd2, X_BINS, Y_BINS, 1'b0, 0, 1'b0, 1'b0);

        // Sparse object with a tie inside the x block, interleaved, clear ack pre-raised.
        for (int i = 0; i < X_BINS; i++) xb[i] = (i >= 50 && i <= 60) ? 8'd20 : 8'd0;
        for (int i = 0; i < Y_BINS; i++) yb[i] = (i >= 100 && i <= 110) ? 8'd20 : 8'd0;
        xb[55] = 8'd20;
        run(8'd10, X_BINS, Y_BINS, 1'b1, 0, 1'b1, 1'b0);

        // No object: nothing strictly above threshold.
        for (int i = 0; i < X_BINS; i++) xb[i] = 8'd5;
        for (int i = 0; i < Y_BINS; i++) yb[i] = 8'd5;
        run(8'd5, X_BINS, Y_BINS, 1'b0, 0, 1'b0, 1'b0);

        // Random data, random gaps, 5 overrun x beats of 255.
        for (int i = 0; i < X_BINS; i++) xb[i] = 8'($urandom_range(0, 200));
        for (int i = 0; i < Y_BINS; i++) yb[i] = 8'($urandom_range(0, 200));
        run(8'd100, X_BINS, Y_BINS, 1'b1, 5, 1'b0, 1'b0);

        // Timeout after x bin 99 and y bin 49.
        for (int i = 0; i < X_BINS; i++) xb[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < Y_BINS; i++) yb[i] = 8'($urandom_range(0, 255));
        run(8'd128, 100, 50, 1'b0, 0, 1'b0, 1'b0);

        // Reset during CLEAR.
        for (int i = 0; i < X_BINS; i++) xb[i] = 8'd7;
        for (int i = 0; i < Y_BINS; i++) yb[i] = 8'd9;
        run(8'd1, X_BINS, Y_BINS, 1'b0, 0, 1'b0, 1'b1);
        check("post_rst_error", error, 1'b0);
        check("post_rst_xSum", xSum, 16'd0);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
